// File: rtl/sbox_share_output_stage.sv
// sbox_share_output_stage: per-share output basis change, affine constant and LFSR mask refresh,
// buffered through a 2-entry FIFO with registered outputs and a sticky overflow flag.
module sbox_share_output_stage #(
  parameter logic [63:0] OUT_MAP   = 64'h8040201008040201,
  parameter logic [7:0]  AFFINE_C  = 8'h63,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_share0,
  input  logic [7:0] in_share1,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_share0,
  output logic [7:0] out_share1,
  output logic       overflow,
  output logic [1:0] count
);
  logic [7:0]  r_lfsr;
  logic [15:0] r_head, r_tail;
  logic [1:0]  r_count;
  logic        r_ovf;
  logic [7:0]  w_m0, w_m1;
  logic [15:0] w_s;
  logic        w_fb, w_pop, w_push;

  function automatic logic [7:0] map_basis(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(OUT_MAP[8*i +: 8] & x);
    return y;
  endfunction

  // Each share goes through its own copy of the matrix so no gate mixes the two shares.
  always_comb begin
    w_m0 = map_basis(in_share0);
    w_m1 = map_basis(in_share1);
  end

  assign w_s    = {w_m0 ^ AFFINE_C ^ r_lfsr, w_m1 ^ r_lfsr};
  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_pop  = out_valid & out_ready;
  assign w_push = in_valid & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= LFSR_SEED;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_lfsr <= {r_lfsr[6:0], w_fb};
      if (in_valid & ~w_push) r_ovf <= 1'b1;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
      if (w_push & ((r_count == 2'd0) | ((r_count == 2'd1) & w_pop))) r_head <= w_s;
      else if (w_pop & (r_count == 2'd2)) r_head <= r_tail;
      if (w_push & ((r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop))) r_tail <= w_s;
    end
  end

  assign in_ready   = (r_count != 2'd2) | out_ready;
  assign out_valid  = r_count != 2'd0;
  assign out_share0 = r_head[15:8];
  assign out_share1 = r_head[7:0];
  assign overflow   = r_ovf;
  assign count      = r_count;
endmodule

// File: tb/tb_sbox_share_output_stage.sv
// tb_sbox_share_output_stage: constant vector table, then queue-based reference model with
// random traffic; a second instance with a non-identity output map checks recombination.
module tb_sbox_share_output_stage;
  localparam logic [63:0] ID_MAP  = 64'h8040201008040201;
  localparam logic [63:0] ALT_MAP = 64'h1F3E7CF8F1E3C78F;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [7:0] in_share0, in_share1;
  logic       in_ready, out_valid, overflow;
  logic [7:0] out_share0, out_share1;
  logic [1:0] count;
  logic       in_ready2, out_valid2, overflow2;
  logic [7:0] out2_share0, out2_share1;
  logic [1:0] count2;

  sbox_share_output_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_share0(in_share0), .in_share1(in_share1),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_share0(out_share0), .out_share1(out_share1), .overflow(overflow), .count(count)
  );

  sbox_share_output_stage #(.OUT_MAP(ALT_MAP)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_share0(in_share0), .in_share1(in_share1),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_share0(out2_share0), .out_share1(out2_share1), .overflow(overflow2), .count(count2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q[$];
  logic [7:0]  m_r;
  logic        m_ovf;
  logic [15:0] m_last;

  typedef struct {
    logic r, iv;
    logic [7:0] a, b;
    logic ordy, ev;
    logic [7:0] e0, e1;
    logic [1:0] ec;
    logic eo;
  } vec_t;
  vec_t tv[10];

  // Matrix-vector product over GF(2): sum of the columns selected by the set input bits.
  function automatic logic [7:0] m_map(input logic [63:0] mp, input logic [7:0] x);
    logic [7:0] y = '0;
    for (int j = 0; j < 8; j++)
      if (x[j]) for (int i = 0; i < 8; i++) y[i] = y[i] ^ mp[8*i + j];
    return y;
  endfunction

  // x^8+x^6+x^5+x^4+1, left shift, feedback into bit 0.
  function automatic logic [7:0] m_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_r = 8'hA5;
    m_ovf = 1'b0;
    m_last = '0;
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [7:0] a, input logic [7:0] b,
                     input logic ordy);
    logic pop, push;
    rst = r; in_valid = iv; in_share0 = a; in_share1 = b; out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
    @(posedge clk);
    if (r) model_reset();
    else begin
      pop  = (q.size() > 0) && ordy;
      push = iv && ((q.size() < 2) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({m_map(ID_MAP, a) ^ 8'h63 ^ m_r, m_map(ID_MAP, b) ^ m_r});
        m_r = m_step(m_r);
      end else if (iv) m_ovf = 1'b1;
      if (q.size() > 0) m_last = q[0];
    end
    #1;
    chk("state", 64'({out_valid, count, overflow, out_share0, out_share1}),
        64'({q.size() > 0, 2'(q.size()), m_ovf, m_last}));
  endtask

  initial begin
    logic [7:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_share0 = '0; in_share1 = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    model_reset();

    tv[0] = '{1'b1, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hC6, 8'hA5, 2'd1, 1'b0};
    tv[2] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC6, 8'hA5, 2'd0, 1'b0};
    tv[3] = '{1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 8'h28, 8'h4A, 2'd1, 1'b0};
    tv[4] = '{1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b1, 8'h28, 8'h4A, 2'd2, 1'b0};
    tv[5] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h28, 8'h4A, 2'd2, 1'b1};
    tv[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF6, 8'h85, 2'd1, 1'b1};
    tv[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hF6, 8'h85, 2'd0, 1'b1};
    tv[8] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h49, 8'h2A, 2'd1, 1'b1};
    tv[9] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rst = tv[i].r; in_valid = tv[i].iv; in_share0 = tv[i].a; in_share1 = tv[i].b;
      out_ready = tv[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), 64'({out_valid, out_share0, out_share1, count, overflow}),
          64'({tv[i].ev, tv[i].e0, tv[i].e1, tv[i].ec, tv[i].eo}));
    end
    model_reset();

    // Full FIFO with simultaneous push and pop keeps count at 2 and raises no overflow.
    cyc(0, 1, 8'h12, 8'h34, 0);
    cyc(0, 1, 8'h56, 8'h78, 0);
    cyc(0, 1, 8'h9A, 8'hBC, 1);
    chk("s4_count", 64'(count), 64'd2);
    cyc(0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, 8'h00, 8'h00, 1);

    // Reset while full and pushing: everything lost, LFSR back to seed.
    cyc(0, 1, 8'hDE, 8'hAD, 0);
    cyc(0, 1, 8'hBE, 8'hEF, 0);
    cyc(1, 1, 8'h77, 8'h88, 1);
    cyc(0, 1, 8'h00, 8'h00, 1);
    chk("s5_seed", 64'({out_share0, out_share1}), 64'h0000_0000_0000_C6A5);

    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cyc(0, 1, a, b, 1);
      chk("s2_recomb", 64'(out_share0 ^ out_share1), 64'(m_map(ID_MAP, a ^ b) ^ 8'h63));
      chk("s2_mask_nz", 64'((out_share1 ^ b) != 8'h00), 64'd1);
    end
    chk("s2_no_ovf", 64'(overflow), 64'd0);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));

    cyc(1, 0, 8'h00, 8'h00, 1);
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cyc(0, 1, a, b, 1);
      chk("s6_recomb", 64'({out_valid2, out2_share0 ^ out2_share1}),
          64'({1'b1, m_map(ALT_MAP, a ^ b) ^ 8'h63}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sbox_share_output_stage.md
SBOX_SHARE_OUTPUT_STAGE -- requirements
Module: sbox_share_output_stage

Interface
REQ-001 The block SHALL have parameter OUT_MAP, default 64'h8040201008040201 (identity): 8x8 GF(2) output basis-change matrix, row i = OUT_MAP[8i+7:8i], result bit i = parity(row i AND input).
REQ-002 The block SHALL have parameter AFFINE_C, default 8'h63: affine constant, added to share 0 only.
REQ-003 The block SHALL have parameter LFSR_SEED, default 8'hA5: nonzero refresh-LFSR reset value.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: upstream masked multiplier output is valid this cycle.
REQ-007 Port in_share0, input, 8: product share 0, as {q0,p0,n0,m0,t0,z0,y0,x0}.
REQ-008 Port in_share1, input, 8: product share 1, same bit order.
REQ-009 Port in_ready, output, 1: status only; the upstream pipeline does not stall on it.
REQ-010 Port out_valid, output, 1: head entry is presented.
REQ-011 Port out_ready, input, 1: consumer accepts the head entry.
REQ-012 Port out_share0, output, 8: S-box output share 0.
REQ-013 Port out_share1, output, 8: S-box output share 1.
REQ-014 Port overflow, output, 1: sticky drop flag.
REQ-015 Port count, output, 2: FIFO occupancy, 0..2.

Function
REQ-016 The block SHALL compute per share, with no gate combining share 0 and share 1 signals: s0 = M(in_share0) ^ AFFINE_C ^ r, and s1 = M(in_share1) ^ r.
REQ-017 r SHALL be the current 8-bit Fibonacci LFSR state, polynomial x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering bit 0.
REQ-018 The LFSR SHALL advance exactly once per accepted input and SHALL hold otherwise.
REQ-019 The block SHALL store (s0,s1) pairs in a 2-entry FIFO with registered outputs.
REQ-020 out_share0/out_share1 SHALL equal the head entry when out_valid=1, and SHALL hold their last value otherwise.
REQ-021 Push: in_valid=1 SHALL be accepted when count<2, or when count==2 with pop in the same cycle.
REQ-022 Pop: a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-023 Latency: input accepted at edge t with FIFO empty SHALL give out_valid=1 with that data in the cycle after t (1 cycle).
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 in_ready SHALL equal (count<2) OR out_ready.
REQ-026 Full and not popping with in_valid=1: the input SHALL be dropped, FIFO and LFSR SHALL be unchanged, and overflow SHALL be set.
REQ-027 overflow SHALL be cleared only by rst.
REQ-028 out_valid SHALL equal (count!=0).
REQ-029 Pop on empty SHALL be impossible, since out_valid=0.
REQ-030 Recombination invariant: out_share0 ^ out_share1 SHALL equal M(in_share0 ^ in_share1) ^ AFFINE_C for every accepted entry.

Reset
REQ-031 rst=1 at an edge SHALL force count=0, out_valid=0, out_share0=out_share1=8'h00, overflow=0, LFSR=LFSR_SEED, and SHALL discard FIFO contents.
REQ-032 rst SHALL take priority over a simultaneous push or pop.
REQ-033 in_valid SHALL be ignored in every cycle with rst=1.
REQ-034 Reset mid-operation SHALL lose all pending entries without flagging overflow.

Verification
REQ-035 Scenario 1: defaults; rst, then one input in_share0=8'h00, in_share1=8'h00 with out_ready=1 -> next cycle out_valid=1, out_share0=8'h63^8'hA5=8'hC6, out_share1=8'hA5; then out_valid=0.
REQ-036 Scenario 2: 256 inputs with random shares, out_ready=1 -> every output has out_share0^out_share1 = (in_share0^in_share1)^8'h63, no overflow, and r never 8'h00.
REQ-037 Scenario 3: out_ready=0, three consecutive inputs -> count goes 1,2,2, third input dropped, overflow=1, LFSR advanced twice; then out_ready=1 -> the two stored entries are output in order, and overflow stays 1.
REQ-038 Scenario 4: count=2, in_valid=1 and out_ready=1 in the same cycle -> input accepted, head popped, count stays 2, overflow stays 0.
REQ-039 Scenario 5: rst asserted with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, overflow=0, and the next r used is 8'hA5.
REQ-040 Scenario 6: OUT_MAP set to a non-identity matrix -> recombined output matches a reference model of M plus 8'h63 for 100 random inputs.
